// File: rtl/ssd_scan_decoder.sv
// Decodes multiplexed active-low seven-segment scan lines back into a 4-digit hex frame.
// Each digit slot must hold steady for STABLE_CYCLES samples before it is captured.
module ssd_scan_decoder #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4194304
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [7:0]  seg,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic        frame_valid,
   output logic        glyph_err,
   output logic [7:0]  err_count,
   output logic        stale
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      QUALIFY  = 2'd1,
      CAPTURED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   samp_q, samp_d;
   logic [15:0]   digits_q, digits_d;
   logic [3:0]    dp_tmp_q, dp_tmp_d;
   logic [3:0]    seen_q, seen_d;
   logic [15:0]   value_q, value_d;
   logic [3:0]    dp_q, dp_d;
   logic          frame_valid_q, frame_valid_d;
   logic          glyph_err_q, glyph_err_d;
   logic [7:0]    err_count_q, err_count_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          stale_q, stale_d;

   logic       slot_valid;
   logic [1:0] slot_idx;
   logic       match;
   logic       capture;
   logic [4:0] dec;

   // Returns {hit, hex} for an active-low abcdefg pattern.
   function automatic logic [4:0] decode_glyph(input logic [6:0] p);
      case (p)
         7'b0000001: decode_glyph = {1'b1, 4'h0};
         7'b1001111: decode_glyph = {1'b1, 4'h1};
         7'b0010010: decode_glyph = {1'b1, 4'h2};
         7'b0000110: decode_glyph = {1'b1, 4'h3};
         7'b1001100: decode_glyph = {1'b1, 4'h4};
         7'b0100100: decode_glyph = {1'b1, 4'h5};
         7'b0100000: decode_glyph = {1'b1, 4'h6};
         7'b0001111: decode_glyph = {1'b1, 4'h7};
         7'b0000000: decode_glyph = {1'b1, 4'h8};
         7'b0000100: decode_glyph = {1'b1, 4'h9};
         7'b0001000: decode_glyph = {1'b1, 4'hA};
         7'b1100000: decode_glyph = {1'b1, 4'hB};
         7'b0110001: decode_glyph = {1'b1, 4'hC};
         7'b1000010: decode_glyph = {1'b1, 4'hD};
         7'b0110000: decode_glyph = {1'b1, 4'hE};
         7'b0111000: decode_glyph = {1'b1, 4'hF};
         default:    decode_glyph = 5'b0;
      endcase
   endfunction

   always_comb begin
      slot_valid = 1'b1;
      slot_idx   = 2'd0;
      case (an)
         4'b1110: slot_idx = 2'd0;
         4'b1101: slot_idx = 2'd1;
         4'b1011: slot_idx = 2'd2;
         4'b0111: slot_idx = 2'd3;
         default: slot_valid = 1'b0;
      endcase
   end

   assign match = slot_valid && ({an, seg} == samp_q);
   assign dec   = decode_glyph(seg[7:1]);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      samp_d        = {an, seg};
      digits_d      = digits_q;
      dp_tmp_d      = dp_tmp_q;
      seen_d        = seen_q;
      value_d       = value_q;
      dp_d          = dp_q;
      frame_valid_d = 1'b0;
      glyph_err_d   = 1'b0;
      err_count_d   = err_count_q;
      tcnt_d        = tcnt_q;
      stale_d       = stale_q;
      capture       = 1'b0;

      case (state_q)
         IDLE: begin
            if (slot_valid) begin
               state_d = QUALIFY;
               cnt_d   = CW'(1);
            end else begin
               cnt_d = '0;
            end
         end
         QUALIFY: begin
            if (!slot_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (match) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q + CW'(1) == CW'(STABLE_CYCLES)) begin
                  capture = 1'b1;
                  state_d = CAPTURED;
               end
            end else begin
               cnt_d = CW'(1);
            end
         end
         CAPTURED: begin
            if (!slot_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!match) begin
               state_d = QUALIFY;
               cnt_d   = CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (capture && dec[4]) begin
         digits_d[{slot_idx, 2'b00} +: 4] = dec[3:0];
         dp_tmp_d[slot_idx]               = ~seg[0];
         tcnt_d                           = '0;
         if ((seen_q | ~an) == 4'b1111) begin
            value_d       = digits_d;
            dp_d          = dp_tmp_d;
            frame_valid_d = 1'b1;
            seen_d        = 4'b0000;
            stale_d       = 1'b0;
         end else begin
            seen_d = seen_q | ~an;
         end
      end else begin
         if (capture) begin
            glyph_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
         end
         // Counter parks at the limit; the partial frame is dropped once on arrival.
         if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
            tcnt_d = tcnt_q + TW'(1);
            if (tcnt_q + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
               stale_d = 1'b1;
               seen_d  = 4'b0000;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         samp_q        <= '1;
         digits_q      <= '0;
         dp_tmp_q      <= '0;
         seen_q        <= '0;
         value_q       <= '0;
         dp_q          <= '0;
         frame_valid_q <= 1'b0;
         glyph_err_q   <= 1'b0;
         err_count_q   <= '0;
         tcnt_q        <= '0;
         stale_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         samp_q        <= samp_d;
         digits_q      <= digits_d;
         dp_tmp_q      <= dp_tmp_d;
         seen_q        <= seen_d;
         value_q       <= value_d;
         dp_q          <= dp_d;
         frame_valid_q <= frame_valid_d;
         glyph_err_q   <= glyph_err_d;
         err_count_q   <= err_count_d;
         tcnt_q        <= tcnt_d;
         stale_q       <= stale_d;
      end
   end

   assign value       = value_q;
   assign dp          = dp_q;
   assign frame_valid = frame_valid_q;
   assign glyph_err   = glyph_err_q;
   assign err_count   = err_count_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_ssd_scan_decoder;

   localparam int S = 4;
   localparam int T = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an  = 4'b1111;
   logic [7:0]  seg = 8'hFF;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        frame_valid;
   logic        glyph_err;
   logic [7:0]  err_count;
   logic        stale;

   ssd_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .an(an), .seg(seg),
      .value(value), .dp(dp), .frame_valid(frame_valid),
      .glyph_err(glyph_err), .err_count(err_count), .stale(stale)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] PAT [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int fv_cnt = 0;
   int ge_cnt = 0;
   int fv_cyc = 0;
   int last_start = 0;
   logic [15:0] fv_val = '0;
   logic [3:0]  fv_dp = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         fv_cnt = fv_cnt + 1;
         fv_cyc = cyc;
         fv_val = value;
         fv_dp  = dp;
      end
      if (glyph_err === 1'b1) ge_cnt = ge_cnt + 1;
   end

   function automatic logic [7:0] glyph(input int d, input bit lit);
      glyph = {PAT[d], ~lit};
   endfunction

   // Called just after a negedge; holds the inputs for n rising edges.
   task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
      an = a;
      seg = s;
      last_start = cyc;
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic cap(input int slot, input int d, input bit lit);
      logic [3:0] a;
      a = ~(4'b0001 << slot);
      drive(a, glyph(d, lit), 6);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      an  = 4'b0000;
      seg = 8'h5A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++; if (value !== 16'h0000) begin n_bad++; $display("FAIL reset_value: got %h want 0000", value); end
      n_cmp++; if (dp !== 4'h0) begin n_bad++; $display("FAIL reset_dp: got %b want 0000", dp); end
      n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL reset_stale: got %b want 0", stale); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
      rst = 1'b0;
      drive(4'b1111, 8'hFF, 2);
   endtask

   task automatic test_frame_decode;
      int f0, st;
      f0 = fv_cnt;
      drive(4'b1110, 8'b00001100, 6);
      drive(4'b1101, 8'b00100101, 6);
      drive(4'b1011, 8'b10011110, 6);
      drive(4'b0111, 8'b00000011, 6);
      st = last_start;
      n_cmp++; if (fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL decode_pulses: got %0d want 1", fv_cnt - f0); end
      n_cmp++; if (fv_val !== 16'h0123) begin n_bad++; $display("FAIL decode_value: got %h want 0123", fv_val); end
      n_cmp++; if (fv_dp !== 4'b0101) begin n_bad++; $display("FAIL decode_dp: got %b want 0101", fv_dp); end
      n_cmp++; if (fv_cyc !== st + S) begin n_bad++; $display("FAIL decode_latency: got cycle %0d want %0d", fv_cyc, st + S); end
      n_cmp++; if (value !== 16'h0123) begin n_bad++; $display("FAIL decode_hold: got %h want 0123", value); end
   endtask

   task automatic test_glitch;
      int f0;
      f0 = fv_cnt;
      drive(4'b1110, glyph(10, 1), S - 1);
      drive(4'b1111, 8'hFF, 2);
      cap(1, 5, 0);
      cap(2, 6, 0);
      cap(3, 7, 0);
      n_cmp++; if (fv_cnt - f0 !== 0) begin n_bad++; $display("FAIL glitch_no_capture: got %0d frames want 0", fv_cnt - f0); end
      drive(4'b1110, glyph(10, 1), S);
      drive(4'b1111, 8'hFF, 1);
      n_cmp++; if (fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL glitch_capture: got %0d frames want 1", fv_cnt - f0); end
      n_cmp++; if (fv_val !== 16'h765A) begin n_bad++; $display("FAIL glitch_value: got %h want 765a", fv_val); end
      n_cmp++; if (fv_dp !== 4'b0001) begin n_bad++; $display("FAIL glitch_dp: got %b want 0001", fv_dp); end
   endtask

   task automatic test_invalid;
      int f0, e0;
      f0 = fv_cnt;
      cap(1, 1, 0);
      cap(2, 2, 0);
      cap(3, 3, 0);
      drive(4'b1100, glyph(8, 0), 20);
      drive(4'b0000, glyph(8, 0), 20);
      n_cmp++; if (fv_cnt - f0 !== 0) begin n_bad++; $display("FAIL invalid_slot: got %0d frames want 0", fv_cnt - f0); end
      e0 = ge_cnt;
      drive(4'b1110, 8'b11111110, 10);
      n_cmp++; if (ge_cnt - e0 !== 1) begin n_bad++; $display("FAIL bad_glyph_pulse: got %0d want 1", ge_cnt - e0); end
      n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL bad_glyph_count: got %0d want 1", err_count); end
      n_cmp++; if (fv_cnt - f0 !== 0) begin n_bad++; $display("FAIL bad_glyph_frame: got %0d frames want 0", fv_cnt - f0); end
      for (int i = 0; i < 300; i++)
         drive((i % 2 == 0) ? 4'b1101 : 4'b1110, 8'b11111110, S);
      n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_saturate: got %0d want 255", err_count); end
      n_cmp++; if (ge_cnt - e0 !== 301) begin n_bad++; $display("FAIL err_pulses: got %0d want 301", ge_cnt - e0); end
   endtask

   task automatic test_timeout;
      int f0;
      f0 = fv_cnt;
      cap(0, 4, 0);
      cap(1, 5, 1);
      cap(2, 6, 0);
      cap(3, 7, 1);
      n_cmp++; if (fv_val !== 16'h7654 || fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL b2b_frame: got %h/%0d want 7654/1", fv_val, fv_cnt - f0); end
      n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL stale_cleared_by_frame: got %b want 0", stale); end
      cap(1, 11, 0);
      cap(2, 12, 0);
      cap(3, 13, 0);
      drive(4'b1111, 8'hFF, T - 3);
      n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL stale_early: got %b want 0", stale); end
      drive(4'b1111, 8'hFF, 1);
      n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL stale_set: got %b want 1", stale); end
      f0 = fv_cnt;
      cap(0, 9, 1);
      n_cmp++; if (fv_cnt - f0 !== 0) begin n_bad++; $display("FAIL stale_seen_cleared: got %0d frames want 0", fv_cnt - f0); end
      cap(1, 11, 0);
      cap(2, 12, 0);
      cap(3, 13, 0);
      n_cmp++; if (fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL stale_recover_frame: got %0d want 1", fv_cnt - f0); end
      n_cmp++; if (value !== 16'hDCB9) begin n_bad++; $display("FAIL stale_recover_value: got %h want dcb9", value); end
      n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL stale_recover_clear: got %b want 0", stale); end
   endtask

   task automatic test_reset_midframe;
      int f0;
      cap(0, 14, 0);
      cap(1, 15, 0);
      rst = 1'b1;
      drive(4'b1111, 8'hFF, 2);
      rst = 1'b0;
      n_cmp++; if (err_count !== 8'd0 || value !== 16'h0000) begin n_bad++; $display("FAIL midreset_clear: got %0d/%h want 0/0000", err_count, value); end
      f0 = fv_cnt;
      cap(2, 1, 0);
      cap(3, 2, 0);
      n_cmp++; if (fv_cnt - f0 !== 0) begin n_bad++; $display("FAIL midreset_partial_dropped: got %0d frames want 0", fv_cnt - f0); end
      cap(0, 3, 1);
      cap(1, 4, 0);
      n_cmp++; if (fv_cnt - f0 !== 1) begin n_bad++; $display("FAIL midreset_frame: got %0d want 1", fv_cnt - f0); end
      n_cmp++; if (value !== 16'h2143 || dp !== 4'b0001) begin n_bad++; $display("FAIL midreset_value: got %h/%b want 2143/0001", value, dp); end
   endtask

   initial begin
      test_reset();
      test_frame_decode();
      test_glitch();
      test_invalid();
      test_timeout();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
